count_step_mod: RTL and testbench
=================================

Name: count_step_mod

Overview:
- Parametrised successor to the team's fixed +1/+2 counter.
- Up/down counter with a programmable step size and a programmable modulo limit.
- Three boundary modes: wrap, saturate and one-shot. One-shot is driven by a small FSM.
- Used as a general event/timebase counter in lab designs.
- Output is fully registered, with terminal-count and done flags.

Parameters:
- WIDTH, 8, counter width in bits (≥2).
- STEP_W, 4, width of the step input (≤WIDTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear; the highest functional priority.
- en  in  1  count enable.
- dir  in  1  0 = count up, 1 = count down.
- step  in  STEP_W  increment/decrement amount.
- limit  in  WIDTH  maximum count value; modulus = limit+1.
- mode  in  2  boundary mode (see package).
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  value to load.
- start  in  1  arms a one-shot run.
- count  out  WIDTH  current count (registered).
- tc  out  1  one-cycle pulse when a boundary is crossed or hit.
- sat  out  1  level; high while count is held at a rail in saturate mode.
- busy  out  1  one-shot RUN state.
- done  out  1  one-shot DONE state.

Behaviour:

Reset and timing
- Reset: rst low asynchronously forces count=0, tc=0, sat=0, state=IDLE (busy=0, done=0).
- Release is synchronous to clk.
- All outputs are registered.
- A change on any input is visible on count/tc one clock later.

Priority per cycle
- Priority order: clear > load > count.
- clear: count=0, tc=0, state=IDLE.
- load: count=min(load_val, limit), tc=0. The FSM state is unchanged.
- count: only when en=1 and counting is permitted (modes WRAP/SAT always; ONESHOT only in RUN).

Arithmetic
- s_eff = min(zero-extended step, limit).
- s_eff=0: count holds, no tc.
- Compute in WIDTH+1 bits so there is no silent overflow.
- Up: nxt = count + s_eff. Overflow when nxt > limit.
- Down: underflow when s_eff > count.

Boundary handling
- WRAP, up overflow: count = nxt - (limit+1), tc=1.
- WRAP, down underflow: count = count + (limit+1) - s_eff, tc=1.
- SAT: clamp to limit (up) or 0 (down).
  - tc=1 only on the cycle the rail is first reached.
  - sat=1 while count sits on the rail with en=1 and the direction pointing into the rail.
- ONESHOT: clamp like SAT, tc=1 on the hit, FSM goes RUN→DONE.
- mode=3 is reserved and behaves as WRAP.
- Non-boundary steps: tc=0.

One-shot FSM
- IDLE: start=1 with mode=ONESHOT → RUN. count loads 0 (dir=0) or limit (dir=1). busy=1 from the next cycle.
- RUN: counts on en. On the boundary hit → DONE.
- DONE: done=1, count holds. start=1 → RUN with re-initialisation as above.
- start while in RUN is ignored.
- A mode change away from ONESHOT in any state → IDLE next cycle; count is kept.

Other boundary rules
- limit lowered below count: the next count cycle treats it as overflow (up) or as a normal step (down). Load always clamps.
- clear or reset mid-run aborts to IDLE.

Decomposition:
- Package count_step_pkg holds:
  - typedef enum logic[1:0] mode_e {MODE_WRAP=0, MODE_SAT=1, MODE_ONESHOT=2, MODE_RSVD=3}.
  - typedef enum logic[1:0] os_state_e {OS_IDLE, OS_RUN, OS_DONE}.
- Sub-module count_step_calc is purely combinational. Inputs: count, s_eff, limit, dir, mode. Outputs: next value, boundary flag, rail flag. It holds the WIDTH+1 arithmetic so it can be unit-tested alone.
- The top level holds the registers, priority mux and FSM.

Test Plan (WIDTH=4, STEP_W=4):
- Reset/priority: hold rst low mid-count at 9 → count=0, tc=0 immediately. Then clear=1 and load=1 with load_val=5 together → count=0.
- WRAP up: limit=9, step=3, en=1, from 0 → 3, 6, 9, 2 (tc=1 on 2), 5. Then dir=1 → 2, then 9 (tc=1).
- SAT: limit=12, step=5, up from 10 → 12 (tc=1), 12 (sat=1, tc=0). dir=1, step=7 → 5, 0 (tc=1), 0 (sat=1).
- ONESHOT: limit=6, step=2, dir=0, start pulse → busy, count 0, 2, 4, 6 (tc=1), then done=1 and count holds at 6 with en high. A second start → 0, busy=1.
- Edges: step=0 → count holds, tc=0. step=15 with limit=7 wraps by 7. load_val=14 with limit=7 → count=7. mode=3 behaves as WRAP.
- Mid-run abort: in ONESHOT RUN at count=4, mode→WRAP → IDLE, count stays 4 and resumes wrapping. Async rst mid-RUN → IDLE, count=0.

Source files
------------

// File: rtl/count_step_pkg.sv
// Shared types for the programmable step/modulo counter: boundary modes and one-shot FSM states.
package count_step_pkg;

  // Boundary behaviour selected by the mode input; RSVD falls back to wrapping.
  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  // One-shot sequencer states.
  typedef enum logic [1:0] {
    OS_IDLE = 2'd0,
    OS_RUN  = 2'd1,
    OS_DONE = 2'd2
  } os_state_e;

endpackage

// File: rtl/count_step_calc.sv
// Purely combinational next-count arithmetic for count_step_mod.
// All sums and differences are formed one bit wider than the counter so
// overflow and underflow are detected explicitly instead of silently wrapping.
module count_step_calc
  import count_step_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic [WIDTH-1:0] s_eff_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic             dir_i,
  input  mode_e            mode_i,
  output logic [WIDTH-1:0] next_o,
  output logic             boundary_o,
  output logic             rail_o
);

  logic [WIDTH:0]   cntX;
  logic [WIDTH:0]   stepX;
  logic [WIDTH:0]   limX;
  logic [WIDTH:0]   modX;
  logic [WIDTH:0]   upSum;
  logic [WIDTH:0]   dnDiff;
  logic [WIDTH-1:0] wrapUp;
  logic [WIDTH-1:0] wrapDn;
  logic             overflow;
  logic             underflow;
  logic             isClamp;

  assign cntX      = {1'b0, count_i};
  assign stepX     = {1'b0, s_eff_i};
  assign limX      = {1'b0, limit_i};
  assign modX      = limX + {{WIDTH{1'b0}}, 1'b1};
  assign upSum     = cntX + stepX;
  assign dnDiff    = cntX - stepX;
  assign wrapUp    = WIDTH'(upSum - modX);
  assign wrapDn    = WIDTH'(cntX + modX - stepX);
  assign overflow  = (upSum > limX);
  assign underflow = (stepX > cntX);
  assign isClamp   = (mode_i == MODE_SAT) || (mode_i == MODE_ONESHOT);

  // Choose the next count and whether this step crosses or lands on a boundary.
  always_comb begin
    next_o     = count_i;
    boundary_o = 1'b0;
    if (s_eff_i != '0) begin
      if (!dir_i) begin
        if (overflow) begin
          if (isClamp) begin
            next_o     = limit_i;
            boundary_o = (mode_i == MODE_ONESHOT) || (count_i != limit_i);
          end else begin
            next_o     = wrapUp;
            boundary_o = 1'b1;
          end
        end else begin
          next_o     = upSum[WIDTH-1:0];
          boundary_o = isClamp && (upSum == limX);
        end
      end else begin
        if (underflow) begin
          if (isClamp) begin
            next_o     = '0;
            boundary_o = (mode_i == MODE_ONESHOT) || (count_i != '0);
          end else begin
            next_o     = wrapDn;
            boundary_o = 1'b1;
          end
        end else begin
          next_o     = dnDiff[WIDTH-1:0];
          boundary_o = isClamp && (dnDiff == '0);
        end
      end
    end
  end

  // Saturate mode is pinned when the count already sits on the rail the direction points at.
  always_comb begin
    rail_o = 1'b0;
    if (mode_i == MODE_SAT) begin
      rail_o = dir_i ? (count_i == '0) : (count_i == limit_i);
    end
  end

endmodule

// File: rtl/count_step_mod.sv
// Up/down counter with programmable step and modulo limit, supporting wrap,
// saturate and one-shot boundary modes. All outputs come straight from registers.
module count_step_mod
  import count_step_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic              dir,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic [1:0]        mode,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              start,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              sat,
  output logic              busy,
  output logic              done
);

  mode_e            modeV;
  os_state_e        state_q;
  os_state_e        state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic             sat_q;
  logic             sat_d;
  logic [WIDTH-1:0] stepX;
  logic [WIDTH-1:0] sEff;
  logic [WIDTH-1:0] loadClamped;
  logic [WIDTH-1:0] calcNext;
  logic             calcBoundary;
  logic             calcRail;
  logic             isOneShot;
  logic             countOk;
  logic             osArm;

  assign modeV       = mode_e'(mode);
  assign isOneShot   = (modeV == MODE_ONESHOT);
  assign stepX       = WIDTH'(step);
  assign sEff        = (stepX > limit) ? limit : stepX;
  assign loadClamped = (load_val > limit) ? limit : load_val;
  assign countOk     = !isOneShot || (state_q == OS_RUN);
  assign osArm       = isOneShot && start && (state_q != OS_RUN);

  count_step_calc #(
    .WIDTH(WIDTH)
  ) u_calc (
    .count_i   (count_q),
    .s_eff_i   (sEff),
    .limit_i   (limit),
    .dir_i     (dir),
    .mode_i    (modeV),
    .next_o    (calcNext),
    .boundary_o(calcBoundary),
    .rail_o    (calcRail)
  );

  // Datapath next state: clear beats load, load beats arming, arming beats counting.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    sat_d   = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = loadClamped;
    end else if (osArm) begin
      count_d = dir ? limit : '0;
    end else if (en && countOk) begin
      count_d = calcNext;
      tc_d    = calcBoundary;
      sat_d   = calcRail;
    end
  end

  // Count, terminal-count pulse and saturation level registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      sat_q   <= sat_d;
    end
  end

  // One-shot state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= OS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // One-shot next state; leaving one-shot mode or clearing always drops back to idle.
  always_comb begin
    state_d = state_q;
    if (clear || !isOneShot) begin
      state_d = OS_IDLE;
    end else if (!load) begin
      case (state_q)
        OS_IDLE: if (start) state_d = OS_RUN;
        OS_RUN:  if (en && calcBoundary) state_d = OS_DONE;
        OS_DONE: if (start) state_d = OS_RUN;
        default: state_d = OS_IDLE;
      endcase
    end
  end

  // One-shot status decoded from the registered state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      OS_RUN:  busy = 1'b1;
      OS_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign sat   = sat_q;

endmodule

// File: tb/tb_count_step_mod.sv
// Scenario bench for count_step_mod at WIDTH=4, STEP_W=4. Expected results are
// queued as stimulus is applied, DUT samples are queued after each edge, and
// each scenario task drains and compares the two queues.
module tb_count_step_mod;
  import count_step_pkg::*;

  localparam int WIDTH  = 4;
  localparam int STEP_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear = 1'b0;
  logic              en = 1'b0;
  logic              dir = 1'b0;
  logic [STEP_W-1:0] step = '0;
  logic [WIDTH-1:0]  limit = '0;
  logic [1:0]        mode = 2'd0;
  logic              load = 1'b0;
  logic [WIDTH-1:0]  loadVal = '0;
  logic              start = 1'b0;
  logic [WIDTH-1:0]  count;
  logic              tc;
  logic              sat;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  logic [7:0] expQ[$];
  logic [7:0] obsQ[$];
  string      nameQ[$];

  count_step_mod #(
    .WIDTH (WIDTH),
    .STEP_W(STEP_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .en      (en),
    .dir     (dir),
    .step    (step),
    .limit   (limit),
    .mode    (mode),
    .load    (load),
    .load_val(loadVal),
    .start   (start),
    .count   (count),
    .tc      (tc),
    .sat     (sat),
    .busy    (busy),
    .done    (done)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic pushExp(input logic [3:0] c, input logic t, input logic s,
                         input logic b, input logic d, input string n);
    expQ.push_back({c, t, s, b, d});
    nameQ.push_back(n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    obsQ.push_back({count, tc, sat, busy, done});
  endtask

  task automatic sampleNow();
    #1;
    obsQ.push_back({count, tc, sat, busy, done});
  endtask

  task automatic setCtl(input logic e, input logic d, input logic [3:0] s,
                        input logic [3:0] l, input logic [1:0] m);
    en    = e;
    dir   = d;
    step  = s;
    limit = l;
    mode  = m;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    logic [7:0] o;
    string      n;
    #2;
    rst = 1'b0;
    pushExp(4'd0, 0, 0, 0, 0, "reset_initial");
    sampleNow();
    rst = 1'b1;
    setCtl(1, 0, 4'd9, 4'd15, MODE_WRAP);
    pushExp(4'd9, 0, 0, 0, 0, "count_to_9");
    tick();
    rst = 1'b0;
    pushExp(4'd0, 0, 0, 0, 0, "async_reset_mid_count");
    sampleNow();
    rst = 1'b1;
    pushExp(4'd9, 0, 0, 0, 0, "count_to_9_again");
    tick();
    clear = 1'b1; load = 1'b1; loadVal = 4'd5;
    pushExp(4'd0, 0, 0, 0, 0, "clear_beats_load");
    tick();
    clear = 1'b0;
    pushExp(4'd5, 0, 0, 0, 0, "load_5");
    tick();
    load = 1'b0;
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); n = nameQ.pop_front(); checks++;
      if (obsQ.size() == 0) begin
        errors++; $display("[TB] FAIL %s: no DUT sample, required %b", n, e);
      end else begin
        o = obsQ.pop_front();
        if (o !== e) begin
          errors++;
          $display("[TB] FAIL %s: count=%0d tc=%b sat=%b busy=%b done=%b, required count=%0d tc=%b sat=%b busy=%b done=%b",
                   n, o[7:4], o[3], o[2], o[1], o[0], e[7:4], e[3], e[2], e[1], e[0]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] e;
    logic [7:0] o;
    string      n;
    logic [3:0] upCnt[5] = '{4'd3, 4'd6, 4'd9, 4'd2, 4'd5};
    logic       upTc[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    setCtl(0, 0, 4'd3, 4'd9, MODE_WRAP);
    load = 1'b1; loadVal = 4'd0;
    pushExp(4'd0, 0, 0, 0, 0, "wrap_load0");
    tick();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pushExp(upCnt[i], upTc[i], 0, 0, 0, $sformatf("wrap_up_%0d", i));
      tick();
    end
    dir = 1'b1;
    pushExp(4'd2, 0, 0, 0, 0, "wrap_down_step");
    tick();
    pushExp(4'd9, 1, 0, 0, 0, "wrap_down_underflow");
    tick();
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); n = nameQ.pop_front(); checks++;
      if (obsQ.size() == 0) begin
        errors++; $display("[TB] FAIL %s: no DUT sample, required %b", n, e);
      end else begin
        o = obsQ.pop_front();
        if (o !== e) begin
          errors++;
          $display("[TB] FAIL %s: count=%0d tc=%b sat=%b busy=%b done=%b, required count=%0d tc=%b sat=%b busy=%b done=%b",
                   n, o[7:4], o[3], o[2], o[1], o[0], e[7:4], e[3], e[2], e[1], e[0]);
        end
      end
    end
  endtask

  task automatic test_sat();
    logic [7:0] e;
    logic [7:0] o;
    string      n;
    setCtl(0, 0, 4'd5, 4'd12, MODE_SAT);
    load = 1'b1; loadVal = 4'd10;
    pushExp(4'd10, 0, 0, 0, 0, "sat_load10");
    tick();
    load = 1'b0; en = 1'b1;
    pushExp(4'd12, 1, 0, 0, 0, "sat_up_hit");
    tick();
    pushExp(4'd12, 0, 1, 0, 0, "sat_up_held");
    tick();
    dir = 1'b1; step = 4'd7;
    pushExp(4'd5, 0, 0, 0, 0, "sat_down_step");
    tick();
    pushExp(4'd0, 1, 0, 0, 0, "sat_down_hit");
    tick();
    pushExp(4'd0, 0, 1, 0, 0, "sat_down_held");
    tick();
    en = 1'b0;
    pushExp(4'd0, 0, 0, 0, 0, "sat_en_low");
    tick();
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); n = nameQ.pop_front(); checks++;
      if (obsQ.size() == 0) begin
        errors++; $display("[TB] FAIL %s: no DUT sample, required %b", n, e);
      end else begin
        o = obsQ.pop_front();
        if (o !== e) begin
          errors++;
          $display("[TB] FAIL %s: count=%0d tc=%b sat=%b busy=%b done=%b, required count=%0d tc=%b sat=%b busy=%b done=%b",
                   n, o[7:4], o[3], o[2], o[1], o[0], e[7:4], e[3], e[2], e[1], e[0]);
        end
      end
    end
  endtask

  task automatic test_oneshot();
    logic [7:0] e;
    logic [7:0] o;
    string      n;
    setCtl(0, 0, 4'd2, 4'd6, MODE_ONESHOT);
    load = 1'b1; loadVal = 4'd3;
    pushExp(4'd3, 0, 0, 0, 0, "os_idle_load3");
    tick();
    load = 1'b0; start = 1'b1;
    pushExp(4'd0, 0, 0, 1, 0, "os_start");
    tick();
    start = 1'b0; en = 1'b1;
    pushExp(4'd2, 0, 0, 1, 0, "os_run_2");
    tick();
    pushExp(4'd4, 0, 0, 1, 0, "os_run_4");
    tick();
    pushExp(4'd6, 1, 0, 0, 1, "os_hit_6");
    tick();
    pushExp(4'd6, 0, 0, 0, 1, "os_done_hold_a");
    tick();
    pushExp(4'd6, 0, 0, 0, 1, "os_done_hold_b");
    tick();
    start = 1'b1;
    pushExp(4'd0, 0, 0, 1, 0, "os_restart");
    tick();
    pushExp(4'd2, 0, 0, 1, 0, "os_start_ignored_in_run");
    tick();
    start = 1'b0;
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); n = nameQ.pop_front(); checks++;
      if (obsQ.size() == 0) begin
        errors++; $display("[TB] FAIL %s: no DUT sample, required %b", n, e);
      end else begin
        o = obsQ.pop_front();
        if (o !== e) begin
          errors++;
          $display("[TB] FAIL %s: count=%0d tc=%b sat=%b busy=%b done=%b, required count=%0d tc=%b sat=%b busy=%b done=%b",
                   n, o[7:4], o[3], o[2], o[1], o[0], e[7:4], e[3], e[2], e[1], e[0]);
        end
      end
    end
  endtask

  task automatic test_edges();
    logic [7:0] e;
    logic [7:0] o;
    string      n;
    setCtl(0, 0, 4'd0, 4'd9, MODE_WRAP);
    load = 1'b1; loadVal = 4'd4;
    pushExp(4'd4, 0, 0, 0, 0, "edge_load4");
    tick();
    load = 1'b0; en = 1'b1;
    pushExp(4'd4, 0, 0, 0, 0, "edge_step_zero");
    tick();
    setCtl(1, 0, 4'd15, 4'd7, MODE_WRAP);
    pushExp(4'd3, 1, 0, 0, 0, "edge_step_clamped_a");
    tick();
    pushExp(4'd2, 1, 0, 0, 0, "edge_step_clamped_b");
    tick();
    load = 1'b1; loadVal = 4'd14;
    pushExp(4'd7, 0, 0, 0, 0, "edge_load_clamped");
    tick();
    load = 1'b0;
    setCtl(1, 0, 4'd3, 4'd7, MODE_RSVD);
    pushExp(4'd2, 1, 0, 0, 0, "edge_rsvd_wrap");
    tick();
    pushExp(4'd5, 0, 0, 0, 0, "edge_rsvd_step");
    tick();
    setCtl(1, 0, 4'd1, 4'd3, MODE_RSVD);
    pushExp(4'd2, 1, 0, 0, 0, "edge_limit_lowered");
    tick();
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); n = nameQ.pop_front(); checks++;
      if (obsQ.size() == 0) begin
        errors++; $display("[TB] FAIL %s: no DUT sample, required %b", n, e);
      end else begin
        o = obsQ.pop_front();
        if (o !== e) begin
          errors++;
          $display("[TB] FAIL %s: count=%0d tc=%b sat=%b busy=%b done=%b, required count=%0d tc=%b sat=%b busy=%b done=%b",
                   n, o[7:4], o[3], o[2], o[1], o[0], e[7:4], e[3], e[2], e[1], e[0]);
        end
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] e;
    logic [7:0] o;
    string      n;
    setCtl(0, 0, 4'd2, 4'd6, MODE_ONESHOT);
    start = 1'b1;
    pushExp(4'd0, 0, 0, 1, 0, "abort_start");
    tick();
    start = 1'b0; en = 1'b1;
    pushExp(4'd2, 0, 0, 1, 0, "abort_run_2");
    tick();
    pushExp(4'd4, 0, 0, 1, 0, "abort_run_4");
    tick();
    setCtl(0, 0, 4'd2, 4'd6, MODE_WRAP);
    pushExp(4'd4, 0, 0, 0, 0, "abort_mode_change");
    tick();
    en = 1'b1;
    pushExp(4'd6, 0, 0, 0, 0, "abort_resume_6");
    tick();
    pushExp(4'd1, 1, 0, 0, 0, "abort_resume_wrap");
    tick();
    setCtl(0, 0, 4'd2, 4'd6, MODE_ONESHOT);
    start = 1'b1;
    pushExp(4'd0, 0, 0, 1, 0, "abort_restart");
    tick();
    start = 1'b0; en = 1'b1;
    pushExp(4'd2, 0, 0, 1, 0, "abort_rerun_2");
    tick();
    rst = 1'b0;
    pushExp(4'd0, 0, 0, 0, 0, "abort_async_reset");
    sampleNow();
    rst = 1'b1;
    pushExp(4'd0, 0, 0, 0, 0, "abort_idle_no_count");
    tick();
    dir = 1'b1; start = 1'b1;
    pushExp(4'd6, 0, 0, 1, 0, "os_down_start");
    tick();
    start = 1'b0;
    pushExp(4'd4, 0, 0, 1, 0, "os_down_4");
    tick();
    pushExp(4'd2, 0, 0, 1, 0, "os_down_2");
    tick();
    pushExp(4'd0, 1, 0, 0, 1, "os_down_hit");
    tick();
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); n = nameQ.pop_front(); checks++;
      if (obsQ.size() == 0) begin
        errors++; $display("[TB] FAIL %s: no DUT sample, required %b", n, e);
      end else begin
        o = obsQ.pop_front();
        if (o !== e) begin
          errors++;
          $display("[TB] FAIL %s: count=%0d tc=%b sat=%b busy=%b done=%b, required count=%0d tc=%b sat=%b busy=%b done=%b",
                   n, o[7:4], o[3], o[2], o[1], o[0], e[7:4], e[3], e[2], e[1], e[0]);
        end
      end
    end
  endtask

  // Scenario sequence and final summary.
  initial begin
    $display("[TB] count_step_mod bench starting");
    test_reset();
    test_wrap();
    test_sat();
    test_oneshot();
    test_edges();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
